// File: rtl/mp3player_soc_mem_arb_pkg.sv
// Shared constants for the on-chip RAM arbiter: default widths, master ids and
// arbitration mode selectors.
package mp3player_soc_mem_arb_pkg;
  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/mp3player_soc_arb2.sv
// Two-way per-cycle grant logic. Owns the last-grant pointer used for round-robin
// and the DMA starvation counter used by fixed priority.
module mp3player_soc_arb2
  import mp3player_soc_mem_arb_pkg::*;
#(
  parameter int PRIO_MODE    = PRIO_RR,
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze,
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] grant
);
  logic       last_grant;
  logic [7:0] starve_cnt;

  always_comb begin
    grant = 2'b00;
    if (!reset && !freeze) begin
      if (req0 && req1) begin
        if (PRIO_MODE == PRIO_RR)
          grant = (last_grant == M_CPU) ? 2'b10 : 2'b01;
        else
          grant = (starve_cnt == 8'(STARVE_LIMIT)) ? 2'b10 : 2'b01;
      end else if (req0) begin
        grant = 2'b01;
      end else if (req1) begin
        grant = 2'b10;
      end
    end
  end

  // Idle and frozen cycles leave last_grant alone so the tie order survives stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= M_DMA;
      starve_cnt <= '0;
    end else begin
      if (grant[0])
        last_grant <= M_CPU;
      else if (grant[1])
        last_grant <= M_DMA;
      if (PRIO_MODE == PRIO_RR || !req1 || grant[1])
        starve_cnt <= '0;
      else if (starve_cnt != 8'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/mp3player_soc_onchip_mem_arbiter.sv
// Shares one single-port RAM (1-cycle read latency) between the CPU data master (m0)
// and the MP3 DMA (m1). Handshake: a master holds read/write stable while waitrequest is
// high; the access is taken in the cycle waitrequest is low, and read data returns with
// readdatavalid exactly one cycle later.
module mp3player_soc_onchip_mem_arbiter
  import mp3player_soc_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int PRIO_MODE    = PRIO_RR,
  parameter int STARVE_LIMIT = 8,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);
  logic       req0, req1, rd_issue;
  logic [1:0] grant;
  logic       rd_pend, rd_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  mp3player_soc_arb2 #(
    .PRIO_MODE   (PRIO_MODE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb2 (
    .clk   (clk),
    .reset (reset),
    .freeze(freeze),
    .req0  (req0),
    .req1  (req1),
    .grant (grant)
  );

  // With no grant the m0 fields pass through; chipselect keeps the RAM idle.
  assign mem_address    = grant[1] ? m1_address    : m0_address;
  assign mem_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant[1] ? m1_writedata  : m0_writedata;
  assign mem_chipselect = |grant;
  assign mem_write      = (grant[0] & m0_write) | (grant[1] & m1_write);

  assign m0_waitrequest = reset | (req0 & ~grant[0]);
  assign m1_waitrequest = reset | (req1 & ~grant[1]);

  assign rd_issue = (grant[0] & m0_read & ~m0_write) | (grant[1] & m1_read & ~m1_write);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= M_CPU;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue)
        rd_owner <= grant[1] ? M_DMA : M_CPU;
    end
  end

  assign m0_readdatavalid = rd_pend & (rd_owner == M_CPU);
  assign m1_readdatavalid = rd_pend & (rd_owner == M_DMA);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
endmodule

// File: tb/tb_mp3player_soc_onchip_mem_arbiter.sv
// Bench for the on-chip RAM arbiter: a round-robin instance and a fixed-priority
// instance (STARVE_LIMIT=3) share stimulus, each backed by its own RAM model.
module tb_mp3player_soc_onchip_mem_arbiter;
  logic clk = 1'b0;
  logic reset, freeze, ram_clr;
  logic [1:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;

  logic        wr0_o [2], wr1_o [2], v0_o [2], v1_o [2];
  logic [31:0] rd0_o [2], rd1_o [2];
  logic [1:0]  ma [2];
  logic [3:0]  mbe [2];
  logic        mcs [2], mwe [2];
  logic [31:0] mwd [2], mrd [2];
  logic [31:0] ram [2][4];

  int total = 0;
  int bad = 0;

  // reference model state, one set per instance
  int          m_last [2], m_starve [2], m_pend [2], m_owner [2], g [2];
  logic [31:0] m_mem [2][4];
  logic [31:0] m_rdata [2];

  always #5 clk = ~clk;

  mp3player_soc_onchip_mem_arbiter #(.PRIO_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(wr0_o[0]),
    .m0_readdata(rd0_o[0]), .m0_readdatavalid(v0_o[0]),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(wr1_o[0]),
    .m1_readdata(rd1_o[0]), .m1_readdatavalid(v1_o[0]),
    .mem_address(ma[0]), .mem_byteenable(mbe[0]), .mem_chipselect(mcs[0]),
    .mem_write(mwe[0]), .mem_writedata(mwd[0]), .mem_readdata(mrd[0]));

  mp3player_soc_onchip_mem_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(3)) dut_fp (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(wr0_o[1]),
    .m0_readdata(rd0_o[1]), .m0_readdatavalid(v0_o[1]),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(wr1_o[1]),
    .m1_readdata(rd1_o[1]), .m1_readdatavalid(v1_o[1]),
    .mem_address(ma[1]), .mem_byteenable(mbe[1]), .mem_chipselect(mcs[1]),
    .mem_write(mwe[1]), .mem_writedata(mwd[1]), .mem_readdata(mrd[1]));

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_clr) begin
        for (int a = 0; a < 4; a++) ram[i][a] <= '0;
        mrd[i] <= '0;
      end else if (mcs[i]) begin
        if (mwe[i]) begin
          for (int b = 0; b < 4; b++)
            if (mbe[i][b]) ram[i][ma[i]][8*b +: 8] <= mwd[i][8*b +: 8];
        end else begin
          mrd[i] <= ram[i][ma[i]];
        end
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // -1 = no grant; instance 0 is round-robin, instance 1 fixed priority with limit 3
  function automatic int model_grant(int i);
    bit r0, r1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (reset || freeze) return -1;
    if (r0 && r1) begin
      if (i == 0) return (m_last[i] == 0) ? 1 : 0;
      return (m_starve[i] == 3) ? 1 : 0;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic settle();
    bit r0, r1;
    #1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_last[i] = 1; m_starve[i] = 0; m_pend[i] = 0; m_owner[i] = 0;
      end
      g[i] = model_grant(i);
      chk($sformatf("wait0_i%0d", i), 32'(wr0_o[i]), 32'(reset | (r0 & (g[i] != 0))));
      chk($sformatf("wait1_i%0d", i), 32'(wr1_o[i]), 32'(reset | (r1 & (g[i] != 1))));
      chk($sformatf("cs_i%0d", i), 32'(mcs[i]), 32'(g[i] >= 0));
      chk($sformatf("we_i%0d", i), 32'(mwe[i]),
          32'((g[i] == 0 && m0_write) || (g[i] == 1 && m1_write)));
      if (g[i] >= 0) begin
        chk($sformatf("addr_i%0d", i), 32'(ma[i]), 32'(g[i] == 1 ? m1_address : m0_address));
        if (mwe[i]) begin
          chk($sformatf("wd_i%0d", i), mwd[i], g[i] == 1 ? m1_writedata : m0_writedata);
          chk($sformatf("be_i%0d", i), 32'(mbe[i]), 32'(g[i] == 1 ? m1_byteenable : m0_byteenable));
        end
      end
      chk($sformatf("valid0_i%0d", i), 32'(v0_o[i]), 32'(m_pend[i] == 1 && m_owner[i] == 0));
      chk($sformatf("valid1_i%0d", i), 32'(v1_o[i]), 32'(m_pend[i] == 1 && m_owner[i] == 1));
      if (m_pend[i] == 1)
        chk($sformatf("rdata_i%0d", i), m_owner[i] == 1 ? rd1_o[i] : rd0_o[i], m_rdata[i]);
    end
  endtask

  task automatic advance();
    bit rd, wr, r1;
    logic [1:0] a;
    logic [3:0] be;
    logic [31:0] d;
    r1 = m1_read | m1_write;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        if (g[i] >= 0) begin
          rd = (g[i] == 1) ? m1_read : m0_read;
          wr = (g[i] == 1) ? m1_write : m0_write;
          a  = (g[i] == 1) ? m1_address : m0_address;
          be = (g[i] == 1) ? m1_byteenable : m0_byteenable;
          d  = (g[i] == 1) ? m1_writedata : m0_writedata;
          if (wr) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) m_mem[i][a][8*b +: 8] = d[8*b +: 8];
            m_pend[i] = 0;
          end else if (rd) begin
            m_pend[i] = 1; m_owner[i] = g[i]; m_rdata[i] = m_mem[i][a];
          end
          m_last[i] = g[i];
        end else begin
          m_pend[i] = 0;
        end
        if (i == 1) m_starve[i] = (r1 && g[i] != 1) ? ((m_starve[i] < 3) ? m_starve[i] + 1 : 3) : 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic set_m(int n, bit rd, bit wr, logic [1:0] a, logic [31:0] d, logic [3:0] be);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; ram_clr = 1'b1;
    set_m(0, 0, 0, 2'd0, '0, 4'h0);
    set_m(1, 0, 0, 2'd0, '0, 4'h0);
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 4; a++) m_mem[i][a] = '0;
    @(negedge clk);
    @(negedge clk);
    ram_clr = 1'b0;
    cyc();
    reset = 1'b0;

    // write then read back on the CPU port
    set_m(0, 0, 1, 2'd2, 32'hDEADBEEF, 4'hF); cyc();
    set_m(0, 1, 0, 2'd2, '0, 4'h0); cyc();
    set_m(0, 0, 0, 2'd0, '0, 4'h0); settle();
    chk("t1_valid0", 32'(v0_o[0]), 32'd1);
    chk("t1_data", rd0_o[0], 32'hDEADBEEF);
    chk("t1_valid1", 32'(v1_o[0]), 32'd0);
    advance();

    // round-robin from reset with both masters reading
    do_reset();
    set_m(0, 1, 0, 2'd2, '0, 4'h0);
    set_m(1, 1, 0, 2'd1, '0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("t2_wait0", 32'(wr0_o[0]), 32'(k % 2));
      chk("t2_wait1", 32'(wr1_o[0]), 32'(1 - k % 2));
      advance();
    end
    set_m(0, 0, 0, 2'd0, '0, 4'h0);
    set_m(1, 0, 0, 2'd0, '0, 4'h0);
    cyc();

    // byte-enable merge via the DMA port
    set_m(1, 0, 1, 2'd3, 32'h11223344, 4'hF); cyc();
    set_m(1, 0, 1, 2'd3, 32'hAABBCCDD, 4'b0101); cyc();
    set_m(1, 1, 0, 2'd3, '0, 4'h0); cyc();
    set_m(1, 0, 0, 2'd0, '0, 4'h0); settle();
    chk("t3_valid1", 32'(v1_o[0]), 32'd1);
    chk("t3_data", rd1_o[0], 32'h11BB33DD);
    advance();

    // fixed priority with starvation relief on the second instance
    do_reset();
    set_m(0, 1, 0, 2'd0, '0, 4'h0);
    set_m(1, 1, 0, 2'd1, '0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t4_wait0", 32'(wr0_o[1]), 32'(k % 4 == 3));
      chk("t4_wait1", 32'(wr1_o[1]), 32'(k % 4 != 3));
      advance();
    end

    // freeze after a read issue
    set_m(1, 0, 0, 2'd0, '0, 4'h0); cyc();
    set_m(1, 1, 0, 2'd1, '0, 4'h0);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      if (k == 0) chk("t5_valid0", 32'(v0_o[0]), 32'd1);
      chk("t5_cs", 32'(mcs[0]), 32'd0);
      chk("t5_wait0", 32'(wr0_o[0]), 32'd1);
      chk("t5_wait1", 32'(wr1_o[0]), 32'd1);
      advance();
    end
    freeze = 1'b0;
    set_m(0, 0, 0, 2'd0, '0, 4'h0);
    set_m(1, 0, 0, 2'd0, '0, 4'h0);
    cyc();

    // reset while a DMA read is in flight
    set_m(1, 1, 0, 2'd3, '0, 4'h0); cyc();
    set_m(1, 0, 0, 2'd0, '0, 4'h0);
    reset = 1'b1;
    settle();
    chk("t6_valid1", 32'(v1_o[0]), 32'd0);
    advance();
    cyc();
    reset = 1'b0;
    set_m(0, 1, 0, 2'd0, '0, 4'h0);
    set_m(1, 1, 0, 2'd1, '0, 4'h0);
    settle();
    chk("t6_wait0", 32'(wr0_o[0]), 32'd0);
    chk("t6_wait1", 32'(wr1_o[0]), 32'd1);
    advance();

    // random traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      freeze = ($urandom_range(0, 9) == 0);
      set_m(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom, 4'($urandom_range(0, 15)));
      set_m(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom, 4'($urandom_range(0, 15)));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
